// File: rtl/cl_seq.sv
// Bit-serial logic sequencer: feeds operand bits LSB first to an external
// 1-bit logic unit and assembles its returned bits into result.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; operands and result hold
// RUN   | one bit per cycle through the external unit, k = bit index
// DONE  | result complete; done pulses for this single cycle
module cl_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cl_a,
    output logic             cl_b,
    output logic [1:0]       cl_s,
    input  logic             cl_y
);

    localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [1:0]       op_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        cl_a      = 1'b0;
        cl_b      = 1'b0;
        cl_s      = 2'b00;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                cl_a = a_reg[k];
                cl_b = b_reg[k];
                cl_s = op_reg;
                if (k == K_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // k is cleared on the last bit so it never leaves 0..WIDTH-1,
    // even when WIDTH is not a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            k      <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
            op_reg <= 2'b00;
            result <= '0;
        end else begin
            if (state == IDLE && start) begin
                a_reg  <= a;
                b_reg  <= b;
                op_reg <= op;
                k      <= '0;
            end else if (state == RUN) begin
                result[k] <= cl_y;
                if (k == K_LAST) begin
                    k <= '0;
                end else begin
                    k <= k + 1'b1;
                end
            end
        end
    end

endmodule
